// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush controller.
// Stall masks are indexed [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB, 1 = stop.
package cpu_ctrl_pkg;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] ERET_CODE_DEF  = 32'h0000_000E;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

  typedef enum logic [0:0] {StRun, StPend} ctrl_state_e;

  // The deepest requesting stage wins: it must also hold every stage in front of it.
  function automatic logic [5:0] merge_stall(input logic id, input logic ex, input logic mem);
    logic [5:0] mask;
    if (mem) begin
      mask = STALL_MEM;
    end else if (ex) begin
      mask = STALL_EX;
    end else if (id) begin
      mask = STALL_ID;
    end else begin
      mask = STALL_NONE;
    end
    return mask;
  endfunction

endpackage

// File: rtl/stall_wdog.sv
// Stall watchdog: saturating count of consecutive stalled cycles with a sticky timeout flag.
// Only instantiated when STALL_WDOG_EN is defined.
module stall_wdog #(
  parameter int unsigned WdogCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic stall_i,
  input  logic clr_i,
  output logic timeout_o
);

  localparam int unsigned CntW = $clog2(WdogCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(WdogCycles);

  logic [CntW-1:0] stall_cnt_d, stall_cnt_q;
  logic            timeout_d, timeout_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!stall_i) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != CntMax) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // Set only on the cycle the limit is reached, so a clear while saturated sticks.
    timeout_d = timeout_q;
    if (clr_i) begin
      timeout_d = 1'b0;
    end else if ((stall_cnt_d == CntMax) && (stall_cnt_q != CntMax)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush producer: merges stage stall requests and redirects on exceptions/ERET.
// Optional STALL_WDOG_EN adds a consecutive-stall watchdog (wdog_clr_i / wdog_timeout_o).
module pipeline_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
  parameter logic [31:0] ERET_CODE   = ERET_CODE_DEF
`ifdef STALL_WDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES = 1024
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
`ifdef STALL_WDOG_EN
  ,
  input  logic        wdog_clr_i,
  output logic        wdog_timeout_o
`endif
);

  ctrl_state_e state_d, state_q;
  logic [31:0] pend_pc_d, pend_pc_q;
  logic [31:0] target;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;

  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    flush     = 1'b0;
    new_pc    = '0;
    stall     = merge_stall(stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
    target    = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;

    unique case (state_q)
      StRun: begin
        if (excepttype_i != '0) begin
          if (stallreq_mem_i) begin
            // Bus still busy: park the target; the mem stall keeps MEM..PC held.
            pend_pc_d = target;
            state_d   = StPend;
          end else begin
            flush  = 1'b1;
            new_pc = target;
          end
        end
      end
      StPend: begin
        // The parked exception is the oldest; new exception inputs are ignored here.
        if (!stallreq_mem_i) begin
          flush   = 1'b1;
          new_pc  = pend_pc_q;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    if (flush) begin
      stall = STALL_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Outputs are combinational, so gate them while reset is held.
  assign stall_o  = rst_n ? stall  : STALL_NONE;
  assign flush_o  = rst_n ? flush  : 1'b0;
  assign new_pc_o = rst_n ? new_pc : '0;

`ifdef STALL_WDOG_EN
  stall_wdog #(
    .WdogCycles (WDOG_CYCLES)
  ) u_stall_wdog (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .stall_i   ((stall_o != STALL_NONE) && !flush_o),
    .clr_i     (wdog_clr_i),
    .timeout_o (wdog_timeout_o)
  );
`else
  // No watchdog in this build.
`endif

endmodule
